lcu_feeder: RTL and testbench

LCU_FEEDER -- requirements
Module: lcu_feeder

---
 rtl/lcu_feeder.sv | 190 +++++++++++++++++++
 tb/tb_lcu_feeder.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcu_feeder.sv
// LCU-order pixel feeder: walks a frame LCU by LCU and streams pixels plus SAO parameters downstream.
// Optional stall counter enabled by defining LCU_FEEDER_STALL_CNT_EN.
//
// state  | meaning
// IDLE   | waiting for start; outputs hold, counters parked at pixel 0
// RUN    | presenting pixels, one transfer per edge with in_en & !busy
// DONE   | one-cycle frame-complete pulse
module lcu_feeder #(
    parameter int IMG_W = 128,
    parameter int IMG_H = 128,
    parameter int PIX_W = 8,
    parameter int PRM_W = 24,
    localparam int AW  = $clog2(IMG_W * IMG_H),
    localparam int PAW = $clog2(IMG_W * IMG_H / 256),
    localparam int XW  = $clog2(IMG_W / 16),
    localparam int YW  = $clog2(IMG_H / 16)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       lcu_size,
    output logic [AW-1:0]    img_addr,
    input  logic [PIX_W-1:0] img_rdata,
    output logic [PAW-1:0]   prm_addr,
    input  logic [PRM_W-1:0] prm_rdata,
    input  logic             busy,
    output logic             in_en,
    output logic [PIX_W-1:0] din,
    output logic [1:0]       sao_type,
    output logic [4:0]       sao_band_pos,
    output logic             sao_eo_class,
    output logic [15:0]      sao_offset,
    output logic [XW-1:0]    lcu_x,
    output logic [YW-1:0]    lcu_y,
    output logic             done,
    output logic [31:0]      stall_cnt
);

    localparam int NX16 = IMG_W / 16;
    localparam int NY16 = IMG_H / 16;
    localparam logic [AW-1:0] W_A = AW'(IMG_W);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [1:0]       r_size;
    logic [5:0]       r_r;
    logic [5:0]       r_c;
    logic [XW-1:0]    r_lx;
    logic [YW-1:0]    r_ly;
    logic             r_in_en;
    logic             r_done;
    logic [PIX_W-1:0] r_din_hold;
    logic [23:0]      r_prm_hold;

    logic [5:0]       w_smax;
    logic [2:0]       w_sh;
    logic [XW-1:0]    w_lx_max;
    logic [YW-1:0]    w_ly_max;
    logic             w_c_last;
    logic             w_r_last;
    logic             w_lx_last;
    logic             w_ly_last;
    logic             w_frame_last;
    logic             w_xfer;
    logic [AW-1:0]    w_row;
    logic [AW-1:0]    w_col;
    logic [PAW-1:0]   w_per;
    logic [23:0]      w_prm;

    always_comb begin
        w_smax = 6'd15;
        case (r_size)
            2'd1:    w_smax = 6'd31;
            2'd2:    w_smax = 6'd63;
            default: w_smax = 6'd15;
        endcase
    end

    // r_size is 0/1/2, so S = 16 << r_size and S/16 = 1 << r_size
    assign w_sh         = 3'd4 + {1'b0, r_size};
    assign w_lx_max     = XW'((NX16 >> r_size) - 1);
    assign w_ly_max     = YW'((NY16 >> r_size) - 1);
    assign w_c_last     = (r_c == w_smax);
    assign w_r_last     = (r_r == w_smax);
    assign w_lx_last    = (r_lx == w_lx_max);
    assign w_ly_last    = (r_ly == w_ly_max);
    assign w_frame_last = w_c_last && w_r_last && w_lx_last && w_ly_last;
    assign w_xfer       = (r_state == S_RUN) && r_in_en && !busy;

    assign w_row    = (AW'(r_ly) << w_sh) + AW'(r_r);
    assign w_col    = (AW'(r_lx) << w_sh) + AW'(r_c);
    assign img_addr = w_row * W_A + w_col;
    assign w_per    = PAW'(NX16 >> r_size);
    assign prm_addr = PAW'(r_ly) * w_per + PAW'(r_lx);
    assign lcu_x    = r_lx << r_size;
    assign lcu_y    = r_ly << r_size;

    // Memory reads are combinational, so pixel and parameter data pass straight
    // through while in_en is high; the hold registers keep the last value otherwise.
    assign w_prm        = r_in_en ? prm_rdata[23:0] : r_prm_hold;
    assign din          = r_in_en ? img_rdata : r_din_hold;
    assign sao_type     = w_prm[23:22];
    assign sao_band_pos = w_prm[21:17];
    assign sao_eo_class = w_prm[16];
    assign sao_offset   = w_prm[15:0];
    assign in_en        = r_in_en;
    assign done         = r_done;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_size     <= 2'd0;
            r_r        <= '0;
            r_c        <= '0;
            r_lx       <= '0;
            r_ly       <= '0;
            r_in_en    <= 1'b0;
            r_done     <= 1'b0;
            r_din_hold <= '0;
            r_prm_hold <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_RUN;
                        r_size  <= (lcu_size == 2'd3) ? 2'd0 : lcu_size;
                        r_in_en <= 1'b1;
                        r_r     <= '0;
                        r_c     <= '0;
                        r_lx    <= '0;
                        r_ly    <= '0;
                    end
                end
                S_RUN: begin
                    if (w_xfer) begin
                        r_din_hold <= img_rdata;
                        r_prm_hold <= prm_rdata[23:0];
                        if (w_frame_last) begin
                            r_state <= S_DONE;
                            r_in_en <= 1'b0;
                            r_done  <= 1'b1;
                            r_r     <= '0;
                            r_c     <= '0;
                            r_lx    <= '0;
                            r_ly    <= '0;
                        end else if (!w_c_last) begin
                            r_c <= r_c + 6'd1;
                        end else begin
                            r_c <= '0;
                            if (!w_r_last) begin
                                r_r <= r_r + 6'd1;
                            end else begin
                                r_r  <= '0;
                                r_lx <= w_lx_last ? '0 : r_lx + 1'b1;
                                r_ly <= w_lx_last ? r_ly + 1'b1 : r_ly;
                            end
                        end
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef LCU_FEEDER_STALL_CNT_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cnt <= '0;
        end else if (r_state == S_IDLE && start) begin
            r_stall_cnt <= '0;
        end else if (r_state == S_RUN && r_in_en && busy && r_stall_cnt != 32'hFFFF_FFFF) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`else
    assign stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_lcu_feeder.sv
// Directed bench for lcu_feeder at 128x128: vector table on captured transfers plus
// hand-written frame sequences for stalls, abort by reset and ignored starts.
module tb_lcu_feeder;

    localparam int W     = 128;
    localparam int NPIX  = 16384;
`ifdef LCU_FEEDER_STALL_CNT_EN
    localparam bit STALL_EN = 1'b1;
`else
    localparam bit STALL_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        busy = 1'b0;
    logic [1:0]  lcu_size = 2'd0;
    logic [13:0] img_addr;
    logic [7:0]  img_rdata;
    logic [5:0]  prm_addr;
    logic [23:0] prm_rdata;
    logic        in_en;
    logic [7:0]  din;
    logic [1:0]  sao_type;
    logic [4:0]  sao_band_pos;
    logic        sao_eo_class;
    logic [15:0] sao_offset;
    logic [2:0]  lcu_x;
    logic [2:0]  lcu_y;
    logic        done;
    logic [31:0] stall_cnt;

    int n_pass = 0;
    int n_tot  = 0;
    int cap_addr [NPIX];
    int cap_lx   [NPIX];
    int cap_ly   [NPIX];
    int cap_prm  [NPIX];

    typedef struct {
        int sz;
        int n;
        int addr;
        int lx;
        int ly;
        int prm;
    } vec_t;
    vec_t vt [10];

    always #5 clk = ~clk;

    function automatic logic [7:0] pix(input int a);
        return 8'((a * 7) ^ (a >> 6));
    endfunction

    function automatic logic [23:0] pw(input int p);
        return {2'(p), 5'(p * 3 + 1), 1'(p >> 1), 16'(p * 1000 + 17)};
    endfunction

    assign img_rdata = pix(int'(img_addr));
    assign prm_rdata = pw(int'(prm_addr));

    lcu_feeder dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .lcu_size     (lcu_size),
        .img_addr     (img_addr),
        .img_rdata    (img_rdata),
        .prm_addr     (prm_addr),
        .prm_rdata    (prm_rdata),
        .busy         (busy),
        .in_en        (in_en),
        .din          (din),
        .sao_type     (sao_type),
        .sao_band_pos (sao_band_pos),
        .sao_eo_class (sao_eo_class),
        .sao_offset   (sao_offset),
        .lcu_x        (lcu_x),
        .lcu_y        (lcu_y),
        .done         (done),
        .stall_cnt    (stall_cnt)
    );

    task automatic check(input string name, input longint act, input longint exp);
        n_tot++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Reference position of transfer n, derived from division rather than counters
    task automatic model(input int eff, input int n, output int addr, output int lx,
                         output int ly, output int prm);
        int s, per, li, wi, r, c, bx, by;
        s   = 16 << eff;
        per = W / s;
        li  = n / (s * s);
        wi  = n % (s * s);
        r   = wi / s;
        c   = wi % s;
        bx  = li % per;
        by  = li / per;
        addr = (by * s + r) * W + bx * s + c;
        lx   = bx * s / 16;
        ly   = by * s / 16;
        prm  = by * per + bx;
    endtask

    // mode: 0 busy low, 1 busy toggling (high on first pixel), 2 busy high 10 cycles on last pixel
    task automatic run_frame(input int size, input int mode, input int abort_at, input int start_at,
                             output int done_cyc, output int nxfer, output int errs,
                             output int first_bad);
        int eff, cyc, hold, ea, ex, ey, ep;
        eff = (size == 3) ? 0 : size;
        done_cyc = -1; nxfer = 0; errs = 0; first_bad = -1; hold = 0;
        @(negedge clk);
        start = 1'b1; lcu_size = 2'(size); busy = (mode == 1);
        @(posedge clk); #1;
        start = 1'b0; lcu_size = ~lcu_size; cyc = 1;
        for (int k = 0; k < 40000; k++) begin
            @(negedge clk);
            if (cyc == 1) check("first in_en one cycle after start", in_en, 1);
            if (done) begin
                done_cyc = cyc;
                if (in_en) errs++;
                break;
            end
            if (!in_en || nxfer >= NPIX) begin
                errs++;
                if (first_bad < 0) first_bad = nxfer;
            end else begin
                model(eff, nxfer, ea, ex, ey, ep);
                if (int'(img_addr) != ea || int'(lcu_x) != ex || int'(lcu_y) != ey ||
                    int'(prm_addr) != ep || din != pix(ea) ||
                    {sao_type, sao_band_pos, sao_eo_class, sao_offset} != pw(ep)) begin
                    errs++;
                    if (first_bad < 0) first_bad = nxfer;
                end
                if (!busy) begin
                    cap_addr[nxfer] = int'(img_addr);
                    cap_lx[nxfer]   = int'(lcu_x);
                    cap_ly[nxfer]   = int'(lcu_y);
                    cap_prm[nxfer]  = int'(prm_addr);
                    nxfer++;
                end
            end
            if (abort_at >= 0 && nxfer == abort_at) return;
            @(posedge clk); #1;
            cyc++;
            start = (cyc == start_at);
            case (mode)
                1: busy = (cyc % 2 == 1);
                2: begin
                    if (nxfer == NPIX - 1 && hold < 10) begin
                        busy = 1'b1;
                        hold++;
                    end else begin
                        busy = 1'b0;
                    end
                end
                default: busy = 1'b0;
            endcase
        end
        @(posedge clk); #1;
        start = 1'b0; busy = 1'b0;
        @(negedge clk);
        check("done single cycle", done, 0);
        check("in_en low after frame", in_en, 0);
        check("din holds last pixel", din, pix(NPIX - 1));
        @(negedge clk);
        check("idle after frame (start with done ignored)", in_en, 0);
    endtask

    task automatic check_table(input int eff);
        foreach (vt[i]) begin
            if (vt[i].sz == eff) begin
                check($sformatf("vec%0d img_addr", i), cap_addr[vt[i].n], vt[i].addr);
                check($sformatf("vec%0d lcu_x", i), cap_lx[vt[i].n], vt[i].lx);
                check($sformatf("vec%0d lcu_y", i), cap_ly[vt[i].n], vt[i].ly);
                check($sformatf("vec%0d prm_addr", i), cap_prm[vt[i].n], vt[i].prm);
            end
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int dc, nx, er, fb;
        int seen;

        vt[0] = '{0, 0,     0,     0, 0, 0};
        vt[1] = '{0, 256,   16,    1, 0, 1};
        vt[2] = '{0, 2048,  2048,  0, 1, 8};
        vt[3] = '{0, 16383, 16383, 7, 7, 63};
        vt[4] = '{2, 4095,  8127,  0, 0, 0};
        vt[5] = '{2, 4096,  64,    4, 0, 1};
        vt[6] = '{2, 8192,  8192,  0, 4, 2};
        vt[7] = '{1, 0,     0,     0, 0, 0};
        vt[8] = '{1, 1024,  32,    2, 0, 1};
        vt[9] = '{1, 4096,  4096,  0, 2, 4};

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("reset in_en", in_en, 0);
        check("reset done", done, 0);
        check("reset din", din, 0);
        check("reset img_addr", img_addr, 0);
        check("reset prm_addr", prm_addr, 0);
        check("reset lcu_x", lcu_x, 0);
        check("reset lcu_y", lcu_y, 0);
        check("reset sao fields", {sao_type, sao_band_pos, sao_eo_class, sao_offset}, 0);
        check("reset stall_cnt", stall_cnt, 0);

        // 64x64 LCUs, no backpressure, start raised again in the done cycle
        run_frame(2, 0, -1, 16385, dc, nx, er, fb);
        check("size64 done cycle", dc, 16385);
        check("size64 transfers", nx, NPIX);
        check($sformatf("size64 sequence errors (first bad %0d)", fb), er, 0);
        check("size64 stall_cnt", stall_cnt, 0);
        check_table(2);

        // 16x16 LCUs with busy toggling every cycle
        run_frame(0, 1, -1, -1, dc, nx, er, fb);
        check("toggle done cycle", dc, 32769);
        check("toggle transfers", nx, NPIX);
        check($sformatf("toggle sequence errors (first bad %0d)", fb), er, 0);
        check("toggle stall_cnt", stall_cnt, STALL_EN ? 16384 : 0);
        check_table(0);

        // abort at transfer 1000 by reset, then a fresh 32x32 frame
        run_frame(0, 0, 1000, -1, dc, nx, er, fb);
        check($sformatf("pre-abort sequence errors (first bad %0d)", fb), er, 0);
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        check("abort in_en", in_en, 0);
        check("abort img_addr", img_addr, 0);
        seen = 0;
        for (int k = 0; k < 30; k++) begin
            if (done) seen++;
            @(negedge clk);
        end
        check("abort no done", seen, 0);
        run_frame(1, 0, -1, -1, dc, nx, er, fb);
        check("size32 done cycle", dc, 16385);
        check("size32 transfers", nx, NPIX);
        check($sformatf("size32 sequence errors (first bad %0d)", fb), er, 0);
        check_table(1);

        // lcu_size=3 behaves as 16, mid-frame start ignored, 10-cycle stall on the last pixel
        run_frame(3, 2, -1, 5000, dc, nx, er, fb);
        check("size3 stall-last done cycle", dc, 16395);
        check("size3 transfers", nx, NPIX);
        check($sformatf("size3 sequence errors (first bad %0d)", fb), er, 0);
        check("stall-last stall_cnt", stall_cnt, STALL_EN ? 10 : 0);
        check_table(0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
